// File: rtl/brush_stamp_writer.sv
// Stamps a clipped square brush centred on the cursor, emitting one pixel write per handshake.
// Build option BRUSH_ROUND_EN (default off): the 5x5 brush skips its four corner pixels.
module brush_stamp_writer #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 9,
  parameter int unsigned COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [X_W-1:0]     cursor_x,
  input  logic [Y_W-1:0]     cursor_y,
  input  logic [1:0]         cursor_size,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [X_W-1:0]     wr_x,
  output logic [Y_W-1:0]     wr_y,
  output logic [COLOR_W-1:0] wr_color
);

  localparam int unsigned XS_W = X_W + 1;
  localparam int unsigned YS_W = Y_W + 1;
  localparam logic [XS_W-1:0] H_LIM = XS_W'(H_RES);
  localparam logic [YS_W-1:0] V_LIM = YS_W'(V_RES);
  localparam logic signed [XS_W-1:0] X_MAX = $signed(XS_W'(H_RES - 1));
  localparam logic signed [YS_W-1:0] Y_MAX = $signed(YS_W'(V_RES - 1));

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     cx_q, cx_d, x0_q, x0_d, x1_q, x1_d, px_q, px_d;
  logic [Y_W-1:0]     cy_q, cy_d, y1_q, y1_d, py_q, py_d;
  logic [1:0]         h_q, h_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;

  logic signed [XS_W-1:0] x_lo, x_hi;
  logic signed [YS_W-1:0] y_lo, y_hi;
  logic [X_W-1:0]         bx0, bx1, sx, nx;
  logic [Y_W-1:0]         by0, by1;
  logic [YS_W-1:0]        sy, ny;
  logic                   off_screen, last;

  // Row-major pointer advance; y is one bit wider so stepping past the last row is visible.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [X_W-1:0] lo,
                                             input logic [X_W-1:0] hi);
    return (x == hi) ? lo : x + X_W'(1);
  endfunction

  function automatic logic [YS_W-1:0] step_y(input logic [X_W-1:0] x, input logic [X_W-1:0] hi,
                                              input logic [YS_W-1:0] y);
    return (x == hi) ? y + YS_W'(1) : y;
  endfunction

`ifdef BRUSH_ROUND_EN
  function automatic logic is_corner(input logic [X_W-1:0] x, input logic [YS_W-1:0] y,
                                     input logic [X_W-1:0] cx, input logic [Y_W-1:0] cy,
                                     input logic [1:0] h);
    logic [XS_W-1:0] xw, cxw;
    logic [YS_W-1:0] cyw;
    xw  = {1'b0, x};
    cxw = {1'b0, cx};
    cyw = {1'b0, cy};
    return (h == 2'd2) && ((xw == cxw - XS_W'(2)) || (xw == cxw + XS_W'(2)))
                       && ((y == cyw - YS_W'(2)) || (y == cyw + YS_W'(2)));
  endfunction
`endif

  // Clipped bounds, first pixel and next-pixel pointer.
  always_comb begin
    x_lo = $signed({1'b0, cx_q}) - $signed(XS_W'(h_q));
    x_hi = $signed({1'b0, cx_q}) + $signed(XS_W'(h_q));
    y_lo = $signed({1'b0, cy_q}) - $signed(YS_W'(h_q));
    y_hi = $signed({1'b0, cy_q}) + $signed(YS_W'(h_q));
    bx0  = x_lo[XS_W-1] ? '0 : X_W'(x_lo);
    by0  = y_lo[YS_W-1] ? '0 : Y_W'(y_lo);
    bx1  = (x_hi > X_MAX) ? X_W'(X_MAX) : X_W'(x_hi);
    by1  = (y_hi > Y_MAX) ? Y_W'(Y_MAX) : Y_W'(y_hi);
    off_screen = ({1'b0, cx_q} >= H_LIM) || ({1'b0, cy_q} >= V_LIM);

    sx = bx0;
    sy = {1'b0, by0};
    nx = step_x(px_q, x0_q, x1_q);
    ny = step_y(px_q, x1_q, {1'b0, py_q});
`ifdef BRUSH_ROUND_EN
    if (is_corner(sx, sy, cx_q, cy_q, h_q)) begin
      sy = step_y(sx, bx1, sy);
      sx = step_x(sx, bx0, bx1);
    end
    if (is_corner(nx, ny, cx_q, cy_q, h_q)) begin
      ny = step_y(nx, x1_q, ny);
      nx = step_x(nx, x0_q, x1_q);
    end
`endif
    last = (ny > {1'b0, y1_q});
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    h_d     = h_q;
    col_d   = col_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    px_d    = px_q;
    py_d    = py_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = cursor_x;
          cy_d    = cursor_y;
          h_d     = (cursor_size == 2'b00) ? 2'd0 : (cursor_size == 2'b10) ? 2'd2 : 2'd1;
          col_d   = color;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x0_d = bx0;
        x1_d = bx1;
        y1_d = by1;
        if (off_screen) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          px_d    = sx;
          py_d    = Y_W'(sy);
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (wr_ready) begin
          if (last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            px_d = nx;
            py_d = Y_W'(ny);
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      h_q     <= '0;
      col_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      h_q     <= h_d;
      col_q   <= col_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      px_q    <= px_d;
      py_q    <= py_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = valid_q;
  assign wr_x     = px_q;
  assign wr_y     = py_q;
  assign wr_color = col_q;

endmodule

// File: tb/tb_brush_stamp_writer.sv
// Scoreboard bench for brush_stamp_writer: expected pixels queued at start, popped on each write handshake.
module tb_brush_stamp_writer;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned COLOR_W = 12;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  logic               clk, rst_n, start, wr_ready, busy, done, wr_valid;
  logic [X_W-1:0]     cursor_x, wr_x;
  logic [Y_W-1:0]     cursor_y, wr_y;
  logic [1:0]         cursor_size;
  logic [COLOR_W-1:0] color, wr_color;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   beats, valid_cycles, done_cnt, done_cyc, first_valid;
  logic pend, prev_valid;
  logic [X_W-1:0]     hold_x;
  logic [Y_W-1:0]     hold_y;
  logic [COLOR_W-1:0] hold_c;

  brush_stamp_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_size(cursor_size), .color(color),
    .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference brush: walk the full square row-major, drop off-screen (and optionally corner) pixels.
  function automatic int push_stamp(input int cx, input int cy, input int sz, input int col);
    int h, n;
    pix_t p;
    n = 0;
    h = (sz == 0) ? 0 : (sz == 2) ? 2 : 1;
    if (cx >= 640 || cy >= 480) return 0;
    for (int y = cy - h; y <= cy + h; y++) begin
      for (int x = cx - h; x <= cx + h; x++) begin
        if (x < 0 || y < 0 || x >= 640 || y >= 480) continue;
`ifdef BRUSH_ROUND_EN
        if (h == 2 && (x == cx - 2 || x == cx + 2) && (y == cy - 2 || y == cy + 2)) continue;
`endif
        p.x = X_W'(x);
        p.y = Y_W'(y);
        p.c = COLOR_W'(col);
        exp_q.push_back(p);
        n++;
      end
    end
    return n;
  endfunction

  task automatic monitor();
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend       = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (pend) begin
          check_eq("hold_valid", int'(wr_valid), 1);
          check_eq("hold_x", int'(wr_x), int'(hold_x));
          check_eq("hold_y", int'(wr_y), int'(hold_y));
          check_eq("hold_color", int'(wr_color), int'(hold_c));
        end
        if (wr_valid && !prev_valid) first_valid = cyc;
        if (wr_valid) valid_cycles++;
        if (wr_valid && wr_ready) begin
          beats++;
          check_eq("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("wr_x", int'(wr_x), int'(e.x));
            check_eq("wr_y", int'(wr_y), int'(e.y));
            check_eq("wr_color", int'(wr_color), int'(e.c));
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check_eq("busy_at_done", int'(busy), 1);
        end
        pend       = wr_valid && !wr_ready;
        hold_x     = wr_x;
        hold_y     = wr_y;
        hold_c     = wr_color;
        prev_valid = wr_valid;
      end
    end
  endtask

  task automatic run_stamp(input int cx, input int cy, input int sz, input int col,
                           input int stall, input int poke_at, input bit poke_done, input string tag);
    int p, n_start, iters, stall_left, v0, d0;
    p  = push_stamp(cx, cy, sz, col);
    v0 = valid_cycles;
    d0 = done_cnt;
    first_valid = -1;
    @(posedge clk); #1;
    cursor_x    = X_W'(cx);
    cursor_y    = Y_W'(cy);
    cursor_size = 2'(sz);
    color       = COLOR_W'(col);
    wr_ready    = (stall == 0);
    start       = 1'b1;
    @(posedge clk); #1;
    n_start    = cyc;
    start      = 1'b0;
    stall_left = stall;
    iters      = 0;
    while (done_cnt == d0 && iters < 300) begin
      if (wr_valid && stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else if (stall_left == 0) begin
        wr_ready = 1'b1;
      end
      start = 1'b0;
      if (poke_at > 0 && iters == poke_at) begin
        start       = 1'b1;
        cursor_x    = X_W'(cx + 7);
        cursor_y    = Y_W'(cy + 3);
        cursor_size = 2'b10;
        color       = COLOR_W'(col ^ 'hFFF);
      end
      if (poke_done && done) start = 1'b1;
      @(posedge clk); #1;
      iters++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, int'(done_cnt != d0), 1);
    check_eq({tag, "_done_cycle"}, done_cyc - n_start, 1 + p + stall);
    check_eq({tag, "_valid_cycles"}, valid_cycles - v0, p + stall);
    if (p > 0) check_eq({tag, "_first_valid"}, first_valid - n_start, 1);
    check_eq({tag, "_busy_after_done"}, int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_idle_busy"}, int'(busy), 0);
    check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_emit();
    int b0, v0, d0;
    void'(push_stamp(300, 200, 2, 'h0F0));
    @(posedge clk); #1;
    cursor_x    = X_W'(300);
    cursor_y    = Y_W'(200);
    cursor_size = 2'b10;
    color       = COLOR_W'('h0F0);
    wr_ready    = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pre_valid", int'(wr_valid), 1);
    check_eq("rst_pre_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", int'(wr_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_wr_x", int'(wr_x), 0);
    exp_q.delete();
    @(posedge clk); #1;
    wr_ready = 1'b1;
    rst_n    = 1'b1;
    b0 = beats;
    v0 = valid_cycles;
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    check_eq("post_rst_beats", beats - b0, 0);
    check_eq("post_rst_valid", valid_cycles - v0, 0);
    check_eq("post_rst_done", done_cnt - d0, 0);
    check_eq("post_rst_busy", int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    cursor_x = '0; cursor_y = '0; cursor_size = '0; color = '0;
    beats = 0; valid_cycles = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
    pend = 1'b0; prev_valid = 1'b0; hold_x = '0; hold_y = '0; hold_c = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_valid", int'(wr_valid), 0);
    check_eq("reset_wr_x", int'(wr_x), 0);
    check_eq("reset_wr_y", int'(wr_y), 0);
    check_eq("reset_wr_color", int'(wr_color), 0);
    rst_n = 1'b1;

    run_stamp(100, 50, 1, 'h0A5, 0, 0, 1'b0, "normal");
    run_stamp(0, 0, 2, 'h111, 0, 0, 1'b0, "large_origin");
    run_stamp(639, 479, 0, 'hFFF, 3, 0, 1'b0, "small_stall");
    run_stamp(10, 10, 3, 'h3C3, 0, 4, 1'b0, "code11_restart");
    run_stamp(700, 20, 1, 'h222, 0, 0, 1'b0, "offscreen");
    run_stamp(320, 240, 2, 'h5A5, 0, 0, 1'b1, "large_done_start");
    run_stamp(637, 478, 2, 'h6B6, 2, 0, 1'b0, "large_corner_br");
    reset_mid_emit();
    run_stamp(200, 100, 1, 'h777, 1, 0, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
